spin_readout_collector: RTL
===========================

// Module: spin_readout_collector
// PURPOSE
//  Consumer end of the control unit's read-out interface.
//  - Captures one spin-state vector from the spin array on every config_dig_spin_read_out_ena_q strobe.
//  - Buffers the vectors in a flop-based FIFO.
//  - Once the final run/rerun is captured, streams every vector out word-serially over a valid/ready link to the GPIO serializer.
//  - Sits between the spin array read-out, the central control unit and the GPIO output path.
// PARAMETERS
//  N_SPIN  50  spin vector width (one bit per spin)
//  DEPTH   16  max stored vectors (runs + reruns); power of 2
//  OUT_W   8   output beat width; BEATS = ceil(N_SPIN/OUT_W) beats per vector
// PORTS
//  i_clk                          in   1            system clock
//  i_rstn                         in   1            async active-low reset
//  conf_sys_ctrl_reg_RESET        in   1            soft-reset level; its rising edge clears the block
//  config_dig_spin_read_out_ena_q in   1            capture strobe, 1 cycle, spin data valid
//  spin_state_in                  in   N_SPIN       spin array read-out bits
//  final_run                      in   1            level; all runs/reruns issued
//  o_data                         out  OUT_W        output beat
//  o_valid                        out  1            beat valid
//  i_ready                        in   1            downstream accepts beat
//  o_last_beat                    out  1            current beat is last of its vector
//  o_last_entry                   out  1            current vector is last stored
//  capture_count                  out  $clog2(DEPTH)+1  vectors stored
//  overflow                       out  1            sticky: a strobe was dropped
//  conf_sys_stat_reg_READOUT_DONE out  1            all vectors drained
// BEHAVIOUR
//  - Reset (i_rstn=0 or soft edge): all outputs 0, state COLLECT, wr_ptr=rd_ptr=beat=0.
//  - Soft edge: registered RESET_q; edge = RESET & !RESET_q. All state clears at that clock edge.
//  - The soft clear has priority over every other event in that cycle.
//  - FSM:
//    - COLLECT -> DRAIN: on the cycle after a strobe is seen with final_run=1.
//    - DRAIN -> DONE: on the handshake of the last beat of the last vector.
//    - DONE: held until reset.
//  - Capture (COLLECT): strobe with capture_count<DEPTH writes mem[wr_ptr] = spin_state_in; wr_ptr and count +1.
//  - Full: if capture_count==DEPTH, the strobe is dropped and overflow is set.
//    - If final_run=1 on that strobe, the FSM still moves to DRAIN.
//  - Strobes in DRAIN or DONE are ignored and set overflow. Stored data is never altered.
//  - DRAIN:
//    - o_valid=1 from the first DRAIN cycle.
//    - o_data = mem[rd_ptr][beat*OUT_W +: OUT_W], combinational from flops.
//    - Bits above N_SPIN-1 read as 0. Vector bit 0 maps to o_data[0] of beat 0.
//  - Handshake:
//    - A beat transfers when o_valid & i_ready.
//    - While o_valid & !i_ready, o_data, o_last_beat and o_last_entry hold stable.
//    - On transfer, beat +1. At beat==BEATS-1, beat=0 and rd_ptr +1.
//  - o_last_beat = (beat==BEATS-1). o_last_entry = (rd_ptr==capture_count-1).
//  - Exit: the last beat of the last vector transfers -> DONE.
//    - In DONE: o_valid=0 and READOUT_DONE=1, from the next cycle on.
//  - capture_count does not decrement while draining; it holds the total stored.
//  - A soft reset mid-DRAIN aborts the drain; o_valid=0 from the next cycle. No partial beat is replayed.
//  - final_run going low during DRAIN is ignored.
// TESTING
//  - 3 strobes with vectors A, B, C; final_run=1 on the 3rd; i_ready=1
//    -> 21 beats in order A, B, C.
//    -> Beat 6 of each vector carries bits [49:48] in o_data[1:0], upper bits 0.
//    -> READOUT_DONE=1 the cycle after beat 21.
//  - Same stimulus, i_ready pattern 1,0,0,1,...
//    -> o_data/flags stable during stalls; exactly 21 transfers; no duplicates.
//  - 17 strobes, final_run on the 17th
//    -> capture_count=16, overflow=1; 112 beats out; 17th vector absent.
//  - Single strobe with final_run=1
//    -> 7 beats; o_last_entry=1 on all; o_last_beat only on beat 6.
//  - Soft reset pulse after 5 transferred beats
//    -> o_valid=0 next cycle, capture_count=0, overflow=0.
//    -> The next strobe is stored at entry 0 and drains correctly.
//  - 2 strobes while in DONE
//    -> overflow=1, READOUT_DONE stays 1, capture_count unchanged.

Source files
------------

// File: rtl/spin_readout_collector.sv
// Spin read-out collector: captures spin-state vectors on read-out strobes into a flop FIFO,
// then streams them word-serially over a valid/ready link once the final run has been captured.
module spin_readout_collector #(
  parameter int unsigned N_SPIN = 50,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      conf_sys_ctrl_reg_RESET,
  input  logic                      config_dig_spin_read_out_ena_q,
  input  logic [N_SPIN-1:0]         spin_state_in,
  input  logic                      final_run,
  output logic [OUT_W-1:0]          o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_last_beat,
  output logic                      o_last_entry,
  output logic [$clog2(DEPTH):0]    capture_count,
  output logic                      overflow,
  output logic                      conf_sys_stat_reg_READOUT_DONE
);

  localparam int unsigned BEATS  = (N_SPIN + OUT_W - 1) / OUT_W;
  localparam int unsigned PAD_W  = BEATS * OUT_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_reset_q;
  logic [N_SPIN-1:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [BEAT_W-1:0]        r_beat;
  logic [CNT_W-1:0]         r_count;
  logic                     r_overflow;
  logic                     r_valid;
  logic                     r_done;

  logic                     w_soft_clr;
  logic                     w_full;
  logic                     w_wr_en;
  logic                     w_xfer;
  logic                     w_last_beat;
  logic                     w_last_entry;
  logic [BEATS-1:0][OUT_W-1:0] w_beats;

  assign w_soft_clr   = conf_sys_ctrl_reg_RESET & ~r_reset_q;
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_wr_en      = ~w_soft_clr & (r_state == S_COLLECT) &
                        config_dig_spin_read_out_ena_q & ~w_full;
  assign w_xfer       = r_valid & i_ready;
  assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
  assign w_last_entry = ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));

  // Zero-extend the stored vector to a whole number of beats; bit 0 lands in beat 0, bit 0.
  assign w_beats = PAD_W'(r_mem[r_rd_ptr]);

  // Beat data and flags are only meaningful while valid; forced to 0 otherwise.
  assign o_data                         = r_valid ? w_beats[r_beat] : '0;
  assign o_valid                        = r_valid;
  assign o_last_beat                    = r_valid & w_last_beat;
  assign o_last_entry                   = r_valid & w_last_entry;
  assign capture_count                  = r_count;
  assign overflow                       = r_overflow;
  assign conf_sys_stat_reg_READOUT_DONE = r_done;

  // Soft-reset level history for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_reset_q <= 1'b0;
    end else begin
      r_reset_q <= conf_sys_ctrl_reg_RESET;
    end
  end

  // Vector storage; contents are never read before being written after a clear.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= spin_state_in;
    end
  end

  // Control FSM with pointers, counters and status flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_COLLECT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_soft_clr) begin
      r_state    <= S_COLLECT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (config_dig_spin_read_out_ena_q) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
              r_count  <= r_count + CNT_W'(1);
            end
            // A final-run strobe ends collection even when it was dropped for lack of space.
            if (final_run) begin
              r_state <= S_DRAIN;
              r_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (config_dig_spin_read_out_ena_q) begin
            r_overflow <= 1'b1;
          end
          if (w_xfer) begin
            if (w_last_beat) begin
              r_beat   <= '0;
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
              if (w_last_entry) begin
                r_state <= S_DONE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (config_dig_spin_read_out_ena_q) begin
            r_overflow <= 1'b1;
          end
        end
        default: begin
          r_state <= S_COLLECT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
